// File: rtl/jtframe_dwnld_buf.sv
// Buffered ROM download path: remaps ioctl bytes through address windows into
// 16-bit SDRAM byte-lane writes, queued in a FIFO; high addresses go to the PROM port.
module jtframe_dwnld_buf #(
  parameter int unsigned              AW         = 22,
  parameter int unsigned              REGIONS    = 4,
  parameter logic [AW*REGIONS-1:0]    REG_START  = {22'h0C000, 22'h08000, 22'h04000, 22'h0},
  parameter logic [AW*REGIONS-1:0]    REG_OFFSET = '0,
  parameter logic [AW-1:0]            PROM_START = 22'h3F_FFFF,
  parameter int unsigned              FIFO_DEPTH = 4,
  parameter bit                       SWAB       = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          ioctl_wr,
  output logic [AW-2:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic [1:0]    prog_mask,
  output logic          prog_we,
  input  logic          prog_rdy,
  output logic          prom_we,
  output logic [AW-1:0] prom_addr,
  output logic [7:0]    prom_data,
  output logic          overflow,
  output logic          dwnld_done,
  output logic [AW-1:0] byte_cnt
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [AW-2:0] addr;
    logic [7:0]    data;
    logic [1:0]    mask;
  } entry_t;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] sel_start, sel_off, byte_addr;
  logic          accept, is_prom, prom_hit, sdram_hit;
  logic          s1_valid;
  entry_t        s1, out_e;
  entry_t        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty, fifo_full, push, pop;
  logic          dl_q, armed, rise, fall;

  // Windows are ascending, so the last matching start is the highest index.
  always_comb begin
    sel_start = REG_START[AW-1:0];
    sel_off   = REG_OFFSET[AW-1:0];
    for (int unsigned r = 1; r < REGIONS; r++) begin
      if (ioctl_addr >= REG_START[r*AW +: AW]) begin
        sel_start = REG_START[r*AW +: AW];
        sel_off   = REG_OFFSET[r*AW +: AW];
      end
    end
    byte_addr = ioctl_addr - sel_start + sel_off;
  end

  assign accept    = downloading & ioctl_wr;
  assign is_prom   = ioctl_addr >= PROM_START;
  assign prom_hit  = accept & is_prom;
  assign sdram_hit = accept & ~is_prom;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1        <= '0;
      prom_we   <= 1'b0;
      prom_addr <= '0;
      prom_data <= '0;
    end else begin
      s1_valid <= sdram_hit;
      prom_we  <= prom_hit;
      if (sdram_hit) begin
        s1.addr <= byte_addr[AW-1:1];
        s1.data <= ioctl_data;
        s1.mask <= (byte_addr[0] ^ SWAB) ? 2'b01 : 2'b10;
      end
      if (prom_hit) begin
        prom_addr <= ioctl_addr - PROM_START;
        prom_data <= ioctl_data;
      end
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
  assign push       = s1_valid & (~fifo_full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= s1;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: if (prog_rdy) begin
        if (!fifo_empty) pop = 1'b1;
        else state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      out_e <= '0;
    end else begin
      state <= state_nxt;
      if (pop) out_e <= fifo_mem[rd_ptr];
    end
  end

  assign prog_we   = (state == ST_WAIT);
  assign prog_addr = out_e.addr;
  assign prog_data = {out_e.data, out_e.data};
  assign prog_mask = out_e.mask;

  assign rise       = downloading & ~dl_q;
  assign fall       = ~downloading & dl_q;
  assign dwnld_done = armed & ~downloading & (state == ST_IDLE) & fifo_empty & ~s1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      dl_q     <= 1'b0;
      armed    <= 1'b0;
      overflow <= 1'b0;
      byte_cnt <= '0;
    end else begin
      dl_q <= downloading;
      if (rise) begin
        armed    <= 1'b0;
        overflow <= 1'b0;
        byte_cnt <= '0;
      end else begin
        if (fall) armed <= 1'b1;
        else if (dwnld_done) armed <= 1'b0;
        if (s1_valid && !push) overflow <= 1'b1;
        byte_cnt <= byte_cnt + AW'(push) + AW'(prom_hit);
      end
    end
  end

endmodule

// File: tb/tb_jtframe_dwnld_buf.sv
// Bench for jtframe_dwnld_buf: directed vectors, back-pressure/done/reset sequences,
// and randomized traffic against an address-arithmetic reference model.
module tb_jtframe_dwnld_buf;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, downloading, ioctl_wr, prog_rdy;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [20:0] prog_addr, sw_prog_addr;
  logic [15:0] prog_data, sw_prog_data;
  logic [1:0]  prog_mask, sw_prog_mask;
  logic        prog_we, sw_prog_we, prom_we, sw_prom_we;
  logic [21:0] prom_addr, sw_prom_addr, byte_cnt, sw_byte_cnt;
  logic [7:0]  prom_data, sw_prom_data;
  logic        overflow, sw_overflow, dwnld_done, sw_dwnld_done;

  jtframe_dwnld_buf #(
    .AW(22), .REGIONS(4),
    .REG_START({22'h0C000, 22'h08000, 22'h04000, 22'h0}),
    .REG_OFFSET({22'h0, 22'h0, 22'h100000, 22'h0}),
    .PROM_START(22'h20000), .FIFO_DEPTH(4), .SWAB(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_mask(prog_mask), .prog_we(prog_we),
    .prog_rdy(prog_rdy), .prom_we(prom_we), .prom_addr(prom_addr),
    .prom_data(prom_data), .overflow(overflow), .dwnld_done(dwnld_done),
    .byte_cnt(byte_cnt)
  );

  jtframe_dwnld_buf #(
    .AW(22), .REGIONS(4),
    .REG_START({22'h0C000, 22'h08000, 22'h04000, 22'h0}),
    .REG_OFFSET({22'h0, 22'h0, 22'h100000, 22'h0}),
    .PROM_START(22'h20000), .FIFO_DEPTH(4), .SWAB(1'b1)
  ) dut_sw (
    .clk(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(sw_prog_addr),
    .prog_data(sw_prog_data), .prog_mask(sw_prog_mask), .prog_we(sw_prog_we),
    .prog_rdy(prog_rdy), .prom_we(sw_prom_we), .prom_addr(sw_prom_addr),
    .prom_data(sw_prom_data), .overflow(sw_overflow), .dwnld_done(sw_dwnld_done),
    .byte_cnt(sw_byte_cnt)
  );

  typedef struct {
    logic        prom;
    logic [21:0] addr;
    logic [1:0]  mask;
    logic [7:0]  data;
  } exp_t;

  typedef struct {
    logic [21:0] addr;
    logic [7:0]  data;
    logic        prom;
    logic [21:0] exp_addr;
    logic [1:0]  exp_mask;
  } vec_t;

  localparam logic [21:0] RS [4] = '{22'h0, 22'h4000, 22'h8000, 22'hC000};
  localparam logic [21:0] RO [4] = '{22'h0, 22'h100000, 22'h0, 22'h0};

  int unsigned n_chk = 0, n_fail = 0;
  int unsigned exp_cnt = 0, outstanding = 0;
  exp_t        sq[$], pq[$];
  vec_t        vt[10];
  exp_t        bp[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [21:0] a, input logic [7:0] d);
    exp_t        m;
    logic [21:0] ba;
    int          r;
    m.data = d;
    if (a >= 22'h20000) begin
      m.prom = 1'b1;
      m.addr = a - 22'h20000;
      m.mask = 2'b11;
    end else begin
      r = 0;
      for (int i = 0; i < 4; i++) if (a >= RS[i]) r = i;
      ba     = a - RS[r] + RO[r];
      m.prom = 1'b0;
      m.addr = ba >> 1;
      m.mask = ba[0] ? 2'b01 : 2'b10;
    end
    return m;
  endfunction

  function automatic logic [1:0] swapped(input logic [1:0] m);
    return {m[0], m[1]};
  endfunction

  // Checks PROM strobes and SDRAM handshakes against the model queues for this cycle.
  task automatic mon();
    exp_t e;
    if (prom_we) begin
      if (pq.size() == 0) chk("rand spurious prom_we", 32'd1, 32'd0);
      else begin
        e = pq.pop_front();
        chk("rand prom_addr", prom_addr, e.addr);
        chk("rand prom_data", prom_data, e.data);
      end
    end
    if (prog_we && prog_rdy) begin
      if (sq.size() == 0) chk("rand spurious prog_we", 32'd1, 32'd0);
      else begin
        e = sq.pop_front();
        outstanding--;
        chk("rand prog_addr", prog_addr, e.addr);
        chk("rand prog_data", prog_data, {e.data, e.data});
        chk("rand prog_mask", prog_mask, e.mask);
        chk("rand swab mask", sw_prog_mask, swapped(e.mask));
      end
    end
  endtask

  initial begin
    int          hs, last_hs;
    logic        any_we, any_done;
    logic [21:0] a;
    logic [7:0]  d;
    exp_t        e;

    vt[0] = '{22'h00005, 8'hA5, 1'b0, 22'h000002, 2'b01};
    vt[1] = '{22'h04002, 8'h5A, 1'b0, 22'h080001, 2'b10};
    vt[2] = '{22'h20010, 8'h3C, 1'b1, 22'h000010, 2'b00};
    vt[3] = '{22'h08001, 8'h11, 1'b0, 22'h000000, 2'b01};
    vt[4] = '{22'h0C000, 8'h22, 1'b0, 22'h000000, 2'b10};
    vt[5] = '{22'h03FFF, 8'h33, 1'b0, 22'h001FFF, 2'b01};
    vt[6] = '{22'h1FFFF, 8'h44, 1'b0, 22'h009FFF, 2'b01};
    vt[7] = '{22'h07FFF, 8'h55, 1'b0, 22'h081FFF, 2'b01};
    vt[8] = '{22'h3FFFFF, 8'h66, 1'b1, 22'h3DFFFF, 2'b00};
    vt[9] = '{22'h20000, 8'h77, 1'b1, 22'h000000, 2'b00};

    rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0; prog_rdy = 1'b0;
    ioctl_addr = '0; ioctl_data = '0;
    repeat (3) @(negedge clk);
    chk("reset prog_we", prog_we, 0);
    chk("reset prog_addr", prog_addr, 0);
    chk("reset prog_data", prog_data, 0);
    chk("reset prog_mask", prog_mask, 0);
    chk("reset prom_we", prom_we, 0);
    chk("reset overflow", overflow, 0);
    chk("reset dwnld_done", dwnld_done, 0);
    chk("reset byte_cnt", byte_cnt, 0);
    rst = 1'b0; downloading = 1'b1;
    @(negedge clk);

    // Directed single-byte vectors, prog_rdy high
    for (int i = 0; i < 10; i++) begin
      ioctl_addr = vt[i].addr; ioctl_data = vt[i].data; ioctl_wr = 1'b1; prog_rdy = 1'b1;
      @(negedge clk);
      ioctl_wr = 1'b0;
      if (vt[i].prom) begin
        chk("vec prom_we", prom_we, 1);
        chk("vec prom_addr", prom_addr, vt[i].exp_addr);
        chk("vec prom_data", prom_data, vt[i].data);
      end else chk("vec prom_we idle", prom_we, 0);
      @(negedge clk);
      chk("vec prom_we one-cycle", prom_we, 0);
      chk("vec prog_we early", prog_we, 0);
      @(negedge clk);
      if (vt[i].prom) chk("vec prom no prog_we", prog_we, 0);
      else begin
        chk("vec prog_we latency", prog_we, 1);
        chk("vec prog_addr", prog_addr, vt[i].exp_addr);
        chk("vec prog_data", prog_data, {vt[i].data, vt[i].data});
        chk("vec prog_mask", prog_mask, vt[i].exp_mask);
        chk("vec swab mask", sw_prog_mask, swapped(vt[i].exp_mask));
      end
      exp_cnt++;
      @(negedge clk);
      chk("vec prog_we released", prog_we, 0);
      chk("vec byte_cnt", byte_cnt, exp_cnt);
    end

    // Randomized traffic, bounded to avoid overflow
    for (int c = 0; c < 400; c++) begin
      prog_rdy = ($urandom_range(0, 3) != 0);
      mon();
      ioctl_wr = 1'b0;
      if ($urandom_range(0, 1) == 1 && outstanding < 4) begin
        if ($urandom_range(0, 7) == 0) a = 22'h20000 + 22'($urandom_range(0, 22'h3DFFFF));
        else a = 22'($urandom_range(0, 22'h1FFFF));
        d = 8'($urandom_range(0, 255));
        e = model(a, d);
        ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
        if (e.prom) pq.push_back(e);
        else begin
          sq.push_back(e);
          outstanding++;
        end
        exp_cnt++;
      end
      @(negedge clk);
    end
    ioctl_wr = 1'b0; prog_rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      mon();
      @(negedge clk);
    end
    chk("rand drained", sq.size() + pq.size(), 0);
    chk("rand overflow", overflow, 0);
    chk("rand byte_cnt", byte_cnt, exp_cnt);

    // Back-pressure: 6 bytes with prog_rdy low, depth 4
    prog_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = 22'h100 + 22'(i); d = 8'hB0 + 8'(i);
      bp[i] = model(a, d);
      ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
      @(negedge clk);
    end
    ioctl_wr = 1'b0;
    chk("bp overflow before drop", overflow, 0);
    repeat (3) @(negedge clk);
    chk("bp overflow", overflow, 1);
    chk("bp byte_cnt", byte_cnt, exp_cnt + 5);
    chk("bp prog_we held", prog_we, 1);
    chk("bp head addr", prog_addr, bp[0].addr);
    downloading = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("bp no early done", dwnld_done, 0);
    end
    prog_rdy = 1'b1;
    hs = 0; last_hs = -10;
    for (int k = 0; k < 12; k++) begin
      chk("bp done timing", dwnld_done, (hs == 5 && k == last_hs + 1) ? 1 : 0);
      if (hs > 0 && hs < 5) chk("bp no gap", prog_we, 1);
      if (prog_we) begin
        if (hs < 5) begin
          chk("bp order addr", prog_addr, bp[hs].addr);
          chk("bp order data", prog_data, {bp[hs].data, bp[hs].data});
          chk("bp order mask", prog_mask, bp[hs].mask);
        end else chk("bp extra write", 32'd1, 32'd0);
        hs++;
        last_hs = k;
      end
      @(negedge clk);
    end
    chk("bp write count", hs, 5);

    // ioctl_wr with downloading low is ignored; counters held
    ioctl_addr = 22'h10; ioctl_data = 8'hEE; ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle wr prog_we", prog_we, 0);
    chk("idle wr byte_cnt held", byte_cnt, exp_cnt + 5);
    chk("idle wr overflow held", overflow, 1);
    chk("idle wr no done", dwnld_done, 0);
    downloading = 1'b1;
    @(negedge clk);
    chk("rise clears byte_cnt", byte_cnt, 0);
    chk("rise clears overflow", overflow, 0);

    // Reset mid-transfer
    prog_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ioctl_addr = 22'h200 + 22'(i); ioctl_data = 8'hC0 + 8'(i); ioctl_wr = 1'b1;
      @(negedge clk);
    end
    ioctl_wr = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid prog_we before rst", prog_we, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid rst prog_we", prog_we, 0);
    chk("mid rst prog_addr", prog_addr, 0);
    chk("mid rst prog_data", prog_data, 0);
    chk("mid rst prog_mask", prog_mask, 0);
    chk("mid rst byte_cnt", byte_cnt, 0);
    chk("mid rst overflow", overflow, 0);
    prog_rdy = 1'b1;
    any_we = 1'b0; any_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      any_we   = any_we | prog_we;
      any_done = any_done | dwnld_done;
    end
    chk("mid no prog_we after rst", any_we, 0);
    chk("mid no done after rst", any_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
